// File: rtl/cpu_defs.sv
// cpu_defs: shared opcode, instruction-class and field-position definitions for the decode stage
package cpu_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam int F_OP = 26;
  localparam int F_RS = 21;
  localparam int F_RT = 16;
  localparam int F_RD = 11;
  localparam int F_SH = 6;
  typedef enum logic [1:0] {T_R = 2'd0, T_I = 2'd1, T_J = 2'd2, T_ILL = 2'd3} inst_type_t;
  function automatic inst_type_t classify(input logic [5:0] op);
    return (op == OP_RTYPE) ? T_R :
           (op == OP_J || op == OP_JAL) ? T_J :
           (op inside {OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
                       OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW}) ? T_I : T_ILL;
  endfunction
endpackage

// File: rtl/inst_decode_if.sv
// inst_decode_if: fetch-side, execute-side and write-back signals of the decode stage
interface inst_decode_if #(parameter int DW = 32);
  logic          in_valid;
  logic [31:0]   in_inst;
  logic [31:0]   in_pc;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic [31:0]   imm_ext;
  logic [25:0]   jaddr;
  logic [1:0]    inst_type;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  modport slave (input in_valid, in_inst, in_pc, out_ready, wb_en, wb_addr, wb_data,
                 output in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
                 imm_ext, jaddr, inst_type, rs_data, rt_data);
  modport master (output in_valid, in_inst, in_pc, out_ready, wb_en, wb_addr, wb_data,
                  input in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
                  imm_ext, jaddr, inst_type, rs_data, rt_data);
endinterface

// File: rtl/inst_decode_reg_file.sv
// reg_file: two async read ports, one sync write port, sync active-low clear, register 0 reads zero
module reg_file #(parameter int NREG = 32, parameter int DW = 32, localparam int AW = $clog2(NREG)) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);
  logic [DW-1:0] mem [NREG];
  always_ff @(posedge Clk)
    if (!Rst)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && waddr != '0)
      mem[waddr] <= wdata;
  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];
endmodule

// File: rtl/inst_decode.sv
// inst_decode: MIPS decode stage with one-entry output register and internal register file
// Define WB_BYPASS_EN to forward same-cycle and held-entry write-backs into the latched operands.
module inst_decode import cpu_defs::*; #(parameter int NREG = 32, parameter int DW = 32) (
  input logic         Clk,
  input logic         Rst,
  inst_decode_if.slave bus
);
  logic          valid;
  logic [31:0]   inst;
  logic [31:0]   pc;
  logic [DW-1:0] rs_q, rt_q, rd1, rd2, rs_new, rt_new;
  logic          accept, hit_rs, hit_rt;
  logic [5:0]    op;
  logic [15:0]   imm;
  assign bus.in_ready = !valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  reg_file #(.NREG(NREG), .DW(DW)) u_rf (
    .Clk, .Rst, .we(bus.wb_en), .waddr(bus.wb_addr), .wdata(bus.wb_data),
    .ra1(bus.in_inst[F_RS +: 5]), .ra2(bus.in_inst[F_RT +: 5]), .rd1, .rd2
  );
`ifdef WB_BYPASS_EN
  logic wb_live;
  assign wb_live = bus.wb_en && bus.wb_addr != '0;
  assign rs_new = (wb_live && bus.wb_addr == bus.in_inst[F_RS +: 5]) ? bus.wb_data : rd1;
  assign rt_new = (wb_live && bus.wb_addr == bus.in_inst[F_RT +: 5]) ? bus.wb_data : rd2;
  assign hit_rs = wb_live && bus.wb_addr == inst[F_RS +: 5];
  assign hit_rt = wb_live && bus.wb_addr == inst[F_RT +: 5];
`else
  assign rs_new = rd1;
  assign rt_new = rd2;
  assign hit_rs = 1'b0;
  assign hit_rt = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      inst  <= bus.in_inst;
      pc    <= bus.in_pc;
      rs_q  <= rs_new;
      rt_q  <= rt_new;
    end else begin
      if (bus.out_ready) valid <= 1'b0;
      if (hit_rs) rs_q <= bus.wb_data;
      if (hit_rt) rt_q <= bus.wb_data;
    end
  end
  // Fields decode from the held word, so a cleared register yields all-zero outputs.
  assign op  = inst[F_OP +: 6];
  assign imm = inst[15:0];
  assign bus.out_valid = valid;
  assign bus.out_pc    = pc;
  assign bus.opcode    = op;
  assign bus.rs        = inst[F_RS +: 5];
  assign bus.rt        = inst[F_RT +: 5];
  assign bus.rd        = inst[F_RD +: 5];
  assign bus.shamt     = inst[F_SH +: 5];
  assign bus.funct     = inst[5:0];
  assign bus.jaddr     = inst[25:0];
  assign bus.inst_type = classify(op);
  assign bus.imm_ext   = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? {16'h0, imm} :
                         (op == OP_LUI) ? {imm, 16'h0} : {{16{imm[15]}}, imm};
  assign bus.rs_data   = rs_q;
  assign bus.rt_data   = rt_q;
endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode: directed vector table plus handshake, write-back and reset sequences for inst_decode
module tb_inst_decode;
  logic clk = 1'b0;
  logic rst;
  int tests = 0, fails = 0;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  always #5 clk = ~clk;
  inst_decode_if bus ();
  inst_decode dut (.Clk(clk), .Rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [1:0]  ty;
  } vec_t;
  vec_t v [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] p, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_inst   = ins;
    bus.in_pc     = p;
    bus.out_ready = ordy;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  initial begin
    v[0] = '{32'h012A4020, 32'h00, 32'h00004020, 32'hDEADBEEF, 32'h00001234, 2'd0};
    v[1] = '{32'h2129FFFF, 32'h04, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 2'd1};
    v[2] = '{32'h3508F000, 32'h08, 32'h0000F000, 32'h0,        32'h0,        2'd1};
    v[3] = '{32'h3C081234, 32'h0C, 32'h12340000, 32'h0,        32'h0,        2'd1};
    v[4] = '{32'hFC000000, 32'h10, 32'h00000000, 32'h0,        32'h0,        2'd3};
    v[5] = '{32'h08000010, 32'h14, 32'h00000010, 32'h0,        32'h0,        2'd2};
    v[6] = '{32'h8D2AFFF0, 32'h18, 32'hFFFFFFF0, 32'hDEADBEEF, 32'h00001234, 2'd1};
    v[7] = '{32'h31288000, 32'h1C, 32'h00008000, 32'hDEADBEEF, 32'h0,        2'd1};
    rst = 1'b0;
    bus.in_valid = 0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1;
    wb(0, 0, 0);
    step(); step();
    chk("rst_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_rs_data", bus.rs_data, 0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
    @(negedge clk); rst = 1'b1; wb(1, 9, 32'hDEADBEEF);
    @(negedge clk); wb(1, 10, 32'h00001234);
    @(negedge clk); wb(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, v[i].inst, v[i].pc, 1);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, bus.out_valid}, 1);
      chk($sformatf("v%0d_pc", i), bus.out_pc, v[i].pc);
      chk($sformatf("v%0d_opcode", i), {26'b0, bus.opcode}, {26'b0, v[i].inst[31:26]});
      chk($sformatf("v%0d_rs", i), {27'b0, bus.rs}, {27'b0, v[i].inst[25:21]});
      chk($sformatf("v%0d_rt", i), {27'b0, bus.rt}, {27'b0, v[i].inst[20:16]});
      chk($sformatf("v%0d_rd", i), {27'b0, bus.rd}, {27'b0, v[i].inst[15:11]});
      chk($sformatf("v%0d_shamt", i), {27'b0, bus.shamt}, {27'b0, v[i].inst[10:6]});
      chk($sformatf("v%0d_funct", i), {26'b0, bus.funct}, {26'b0, v[i].inst[5:0]});
      chk($sformatf("v%0d_jaddr", i), {6'b0, bus.jaddr}, {6'b0, v[i].inst[25:0]});
      chk($sformatf("v%0d_type", i), {30'b0, bus.inst_type}, {30'b0, v[i].ty});
      chk($sformatf("v%0d_imm", i), bus.imm_ext, v[i].imm);
      chk($sformatf("v%0d_rs_data", i), bus.rs_data, v[i].rsd);
      chk($sformatf("v%0d_rt_data", i), bus.rt_data, v[i].rtd);
    end
    drive(0, 0, 0, 1);
    step();
    chk("drain_valid", {31'b0, bus.out_valid}, 0);
    // Backpressure: entry held for 3 cycles while the next instruction waits
    drive(1, 32'h012A4020, 32'h100, 0);
    step();
    chk("hold_valid", {31'b0, bus.out_valid}, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h3508F000, 32'h104, 0);
      wb(k == 0, 9, 32'h77);
      #1;
      chk($sformatf("hold%0d_in_ready", k), {31'b0, bus.in_ready}, 0);
      step();
      chk($sformatf("hold%0d_pc", k), bus.out_pc, 32'h100);
      chk($sformatf("hold%0d_imm", k), bus.imm_ext, 32'h4020);
      chk($sformatf("hold%0d_rs_data", k), bus.rs_data, BYP ? 32'h77 : 32'hDEADBEEF);
      wb(0, 0, 0);
    end
    drive(1, 32'h3508F000, 32'h104, 1);
    #1;
    chk("release_in_ready", {31'b0, bus.in_ready}, 1);
    step();
    chk("release_pc", bus.out_pc, 32'h104);
    chk("release_imm", bus.imm_ext, 32'h0000F000);
    chk("release_valid", {31'b0, bus.out_valid}, 1);
    // Write-back in the accept cycle
    drive(1, 32'h012A4020, 32'h108, 1);
    wb(1, 10, 32'h55);
    step();
    chk("samecyc_rt_data", bus.rt_data, BYP ? 32'h55 : 32'h1234);
    chk("samecyc_rs_data", bus.rs_data, 32'h77);
    drive(1, 32'h012A4020, 32'h10C, 1);
    wb(0, 0, 0);
    step();
    chk("after_wb_rt_data", bus.rt_data, 32'h55);
    drive(1, 32'h00000020, 32'h110, 1);
    wb(1, 0, 32'h7);
    step();
    chk("r0_samecyc_rs", bus.rs_data, 0);
    chk("r0_samecyc_rt", bus.rt_data, 0);
    drive(1, 32'h00000020, 32'h114, 1);
    wb(0, 0, 0);
    step();
    chk("r0_after_rs", bus.rs_data, 0);
    // Reset while an entry is held
    drive(1, 32'h012A4020, 32'h118, 0);
    step();
    chk("prerst_valid", {31'b0, bus.out_valid}, 1);
    drive(0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk("rst2_valid", {31'b0, bus.out_valid}, 0);
    chk("rst2_pc", bus.out_pc, 0);
    chk("rst2_rs_data", bus.rs_data, 0);
    chk("rst2_imm", bus.imm_ext, 0);
    chk("rst2_type", {30'b0, bus.inst_type}, 0);
    @(negedge clk); rst = 1'b1;
    for (int r = 1; r < 32; r++) begin
      logic [4:0] a;
      a = 5'(r);
      drive(1, {6'h0, a, a, 16'h0020}, 32'h200 + 32'(r), 1);
      step();
      chk($sformatf("clr_r%0d_rs", r), bus.rs_data, 0);
      chk($sformatf("clr_r%0d_rt", r), bus.rt_data, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
